axi_lite_regfile: RTL and testbench

AXI-Lite subordinate (responder) end: accepts AW/W/AR from a bridge or initiator and returns B/R responses. Backed by NUM_REGS 32-bit registers with byte-strobe writes.
Sits behind bridge_1xM outputs as a leaf peripheral, driving hardware through a flat register bus.
All handshakes obey the valid-hold rule on the outputs it drives (b_valid, r_valid).

---
 rtl/axi_lite_pkg.sv | 12 +
 rtl/axi_lite_regfile.sv | 167 ++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the response type.
// Reused by the register file and by the bridges in front of it.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_regfile.sv
// AXI-Lite subordinate backed by NUM_REGS 32-bit registers with byte-strobe writes.
// Define AXIL_REGFILE_DECERR_EN to answer out-of-range accesses with DECERR instead of SLVERR.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [ADDR_W-1:0]      aw_addr,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [31:0]            w_data,
  input  logic [3:0]             w_strb,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [1:0]             b_resp,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  input  logic [ADDR_W-1:0]      ar_addr,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [31:0]            r_data,
  output logic [1:0]             r_resp,
  output logic [NUM_REGS*32-1:0] regs_o
);

  localparam int IDX_AW = ADDR_W - 2;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_REGFILE_DECERR_EN
  localparam resp_t RESP_OOR = RESP_DECERR;
`else
  localparam resp_t RESP_OOR = RESP_SLVERR;
`endif

  function automatic logic in_range(input logic [IDX_AW-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  logic              aw_full_q, aw_full_d;
  logic [IDX_AW-1:0] aw_idx_q, aw_idx_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              b_valid_q, b_valid_d;
  resp_t             b_resp_q, b_resp_d;
  logic              r_valid_q, r_valid_d;
  logic [31:0]       r_data_q, r_data_d;
  resp_t             r_resp_q, r_resp_d;

  logic              wr_commit;
  logic [IDX_AW-1:0] ar_idx;
  logic              unused_addr_lsbs;

  assign ar_idx           = ar_addr[ADDR_W-1:2];
  assign unused_addr_lsbs = ^{aw_addr[1:0], ar_addr[1:0]};

  // Ready depends only on registered state so an initiator can never form a combinational loop.
  assign aw_ready  = !aw_full_q && !b_valid_q;
  assign w_ready   = !w_full_q && !b_valid_q;
  assign ar_ready  = !r_valid_q;
  assign wr_commit = aw_full_q && w_full_q;

  assign b_valid = b_valid_q;
  assign b_resp  = b_resp_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_resp  = r_resp_q;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;

    if (aw_valid && aw_ready) begin
      aw_full_d = 1'b1;
      aw_idx_d  = aw_addr[ADDR_W-1:2];
    end
    if (w_valid && w_ready) begin
      w_full_d = 1'b1;
      w_data_d = w_data;
      w_strb_d = w_strb;
    end

    if (wr_commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = in_range(aw_idx_q) ? RESP_OKAY : RESP_OOR;
    end else if (b_valid_q && b_ready) begin
      b_valid_d = 1'b0;
    end

    // Register values are sampled before this edge's commit, so a colliding read sees the old data.
    if (ar_valid && ar_ready) begin
      r_valid_d = 1'b1;
      if (in_range(ar_idx)) begin
        r_data_d = regs_o[32*ar_idx[IDX_W-1:0] +: 32];
        r_resp_d = RESP_OKAY;
      end else begin
        r_data_d = 32'h0;
        r_resp_d = RESP_OOR;
      end
    end else if (r_valid_q && r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_data_q  <= 32'h0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [31:0] reg_q, reg_d;

    always_comb begin
      reg_d = reg_q;
      if (wr_commit && aw_idx_q == IDX_AW'(gi)) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb_q[b]) reg_d[8*b +: 8] = w_data_q[8*b +: 8];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) reg_q <= RESET_VAL;
      else     reg_q <= reg_d;
    end

    assign regs_o[32*gi +: 32] = reg_q;
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: directed scenarios plus randomized traffic
// checked against an array model of the register file.
module tb_axi_lite_regfile;

  localparam int NUM_REGS = 16;
`ifdef AXIL_REGFILE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b10;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   aw_valid = 1'b0;
  logic                   aw_ready;
  logic [11:0]            aw_addr = '0;
  logic                   w_valid = 1'b0;
  logic                   w_ready;
  logic [31:0]            w_data = '0;
  logic [3:0]             w_strb = '0;
  logic                   b_valid;
  logic                   b_ready = 1'b1;
  logic [1:0]             b_resp;
  logic                   ar_valid = 1'b0;
  logic                   ar_ready;
  logic [11:0]            ar_addr = '0;
  logic                   r_valid;
  logic                   r_ready = 1'b1;
  logic [31:0]            r_data;
  logic [1:0]             r_resp;
  logic [NUM_REGS*32-1:0] regs_o;

  axi_lite_regfile #(.ADDR_W(12), .NUM_REGS(NUM_REGS), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] model [NUM_REGS];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  logic        prev_bstall = 1'b0;
  logic [1:0]  prev_bresp  = '0;
  logic        prev_rstall = 1'b0;
  logic [31:0] prev_rdata  = '0;
  logic [1:0]  prev_rresp  = '0;

  always @(negedge clk) begin
    logic [1:0] be;
    r_exp_t     re;
    if (!rst) begin
      if (prev_bstall) begin
        check("b_hold_valid", 32'(b_valid), 32'd1);
        check("b_hold_resp", 32'(b_resp), 32'(prev_bresp));
      end
      if (prev_rstall) begin
        check("r_hold_valid", 32'(r_valid), 32'd1);
        check("r_hold_data", r_data, prev_rdata);
        check("r_hold_resp", 32'(r_resp), 32'(prev_rresp));
      end
      if (b_valid && b_ready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got response 0x%0h required none", b_resp);
        end else begin
          be = b_q.pop_front();
          check("b_resp", 32'(b_resp), 32'(be));
          $display("B  resp=%0h", b_resp);
        end
      end
      if (r_valid && r_ready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got data 0x%08h required none", r_data);
        end else begin
          re = r_q.pop_front();
          check("r_data", r_data, re.data);
          check("r_resp", 32'(r_resp), 32'(re.resp));
          $display("R  data=%08h resp=%0h", r_data, r_resp);
        end
      end
    end
    prev_bstall = !rst && b_valid && !b_ready;
    prev_bresp  = b_resp;
    prev_rstall = !rst && r_valid && !r_ready;
    prev_rdata  = r_data;
    prev_rresp  = r_resp;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs();
    for (int k = 0; k < NUM_REGS; k++)
      check($sformatf("reg%0d", k), regs_o[32*k +: 32], model[k]);
  endtask

  task automatic wait_b(input bit rnd);
    int n = 0;
    while (b_q.size() != 0 && n < 200) begin
      b_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    b_ready = 1'b1;
    if (b_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL b_timeout: got %0d pending required 0", b_q.size());
      b_q.delete();
    end
  endtask

  task automatic wait_r(input bit rnd);
    int n = 0;
    while (r_q.size() != 0 && n < 200) begin
      r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    r_ready = 1'b1;
    if (r_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL r_timeout: got %0d pending required 0", r_q.size());
      r_q.delete();
    end
  endtask

  // Issues AW and W with independent start delays; expectation and model update happen here.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_delay, input int w_delay);
    int idx = int'(addr[11:2]);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    if (idx < NUM_REGS) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      b_q.push_back(2'b00);
    end else begin
      b_q.push_back(OOR_RESP);
    end
    $display("W  addr=%03h data=%08h strb=%b", addr, data, strb);
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_valid = !aw_done && cyc >= aw_delay;
      aw_addr  = addr;
      w_valid  = !w_done && cyc >= w_delay;
      w_data   = data;
      w_strb   = strb;
      @(negedge clk);
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL aw_w_timeout: got aw=%0d w=%0d required both accepted", aw_done, w_done);
    end
  endtask

  task automatic wr_full(input logic [11:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_delay, input int w_delay);
    do_write(addr, data, strb, aw_delay, w_delay);
    wait_b(1);
    check_regs();
  endtask

  task automatic do_read(input logic [11:0] addr, input int delay, input bit rnd);
    int     idx = int'(addr[11:2]);
    int     n = 0;
    bit     hs = 0;
    r_exp_t e;
    if (idx < NUM_REGS) begin
      e.data = model[idx];
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = OOR_RESP;
    end
    r_q.push_back(e);
    $display("AR addr=%03h", addr);
    repeat (delay) tick();
    ar_valid = 1'b1;
    ar_addr  = addr;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = ar_ready;
      tick();
      n++;
    end
    ar_valid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got no handshake required one");
    end
    wait_r(rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] old2;
    bit          hs, seen;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_b_resp", 32'(b_resp), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_data", r_data, 32'h0);
    check("rst_r_resp", 32'(r_resp), 32'd0);
    check("rst_aw_ready", 32'(aw_ready), 32'd1);
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_ar_ready", 32'(ar_ready), 32'd1);
    check_regs();

    // Same-cycle AW+W: b_valid rises after the second edge
    aw_valid = 1'b1; aw_addr = 12'h008;
    w_valid = 1'b1; w_data = 32'hDEADBEEF; w_strb = 4'hF;
    b_q.push_back(2'b00);
    model[2] = 32'hDEADBEEF;
    $display("W  addr=008 data=deadbeef strb=1111 (latency)");
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    check("b_lat_early", 32'(b_valid), 32'd0);
    tick();
    check("b_lat_valid", 32'(b_valid), 32'd1);
    check("b_lat_resp", 32'(b_resp), 32'd0);
    check("reg2_deadbeef", regs_o[95:64], 32'hDEADBEEF);
    wait_b(0);
    do_read(12'h008, 0, 0);

    // W first, AW three cycles later, B stalled for five cycles
    b_ready = 1'b0;
    do_write(12'h004, 32'h11223344, 4'b0101, 3, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_b_valid", 32'(b_valid), 32'd1);
      check("stall_aw_ready", 32'(aw_ready), 32'd0);
      check("stall_w_ready", 32'(w_ready), 32'd0);
      tick();
    end
    check("reg1_strobed", regs_o[63:32], 32'h00220044);
    wait_b(0);
    check_regs();

    // Out-of-range read and write
    do_read(12'h040, 0, 0);
    wr_full(12'h040, 32'hCAFEF00D, 4'hF, 0, 0);
    wr_full(12'h00C, 32'h12345678, 4'h0, 1, 0);

    // Read of reg2 on the same edge as a write commit to reg2
    wr_full(12'h008, 32'h0, 4'hF, 0, 0);
    old2 = model[2];
    aw_valid = 1'b1; aw_addr = 12'h008;
    w_valid = 1'b1; w_data = 32'hAAAA5555; w_strb = 4'hF;
    b_q.push_back(2'b00);
    r_q.push_back('{data: old2, resp: 2'b00});
    model[2] = 32'hAAAA5555;
    $display("W  addr=008 data=aaaa5555 strb=1111 (collide with AR)");
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_valid = 1'b1; ar_addr = 12'h008;
    tick();
    ar_valid = 1'b0;
    wait_b(0);
    wait_r(0);
    do_read(12'h008, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [11:0] a;
      a = (12'($urandom_range(0, 19)) << 2) | 12'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        wr_full(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2), 1);
    end

    // Reset with AW buffered and r_valid pending
    aw_valid = 1'b1; aw_addr = 12'h00C;
    ar_valid = 1'b1; ar_addr = 12'h008;
    r_ready = 1'b0;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    check("pre_rst_r_valid", 32'(r_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_ready = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;
    check("mid_rst_b_valid", 32'(b_valid), 32'd0);
    check("mid_rst_r_valid", 32'(r_valid), 32'd0);
    check("mid_rst_aw_ready", 32'(aw_ready), 32'd1);
    check_regs();

    w_valid = 1'b1; w_data = 32'h55AA55AA; w_strb = 4'hF;
    $display("W  data=55aa55aa alone after reset");
    @(negedge clk);
    hs = w_ready;
    tick();
    w_valid = 1'b0;
    check("w_alone_hs", 32'(hs), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_valid) seen = 1;
    end
    check("w_alone_no_b", 32'(seen), 32'd0);
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
